regfile_bypass: RTL and testbench

- 32-entry x 64-bit architectural register file for the pipelined LEGv8 CPU, read in the ID stage and written from the WB stage.
- Holds the register storage, the write-address decoder and two combinational read ports built from the team's 64-bit 32:1 read multiplexor.
- Adds write-to-read bypass so an ID-stage read of a register being written by WB in the same cycle returns the new value.
- X31 (XZR) is hardwired to zero.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_bypass_mux32.sv | 18 +
 rtl/regfile_bypass_reg64_en.sv | 30 +++
 rtl/regfile_bypass.sv | 98 +++++++++
 tb/tb_regfile_bypass.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the LEGv8 register file and the ID-stage
// forwarding logic.
//   DATA_W   : register width in bits
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   XZR      : index of the hardwired zero register
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t XZR = 5'd31;

endpackage : regfile_pkg

// File: rtl/regfile_bypass_mux32.sv
// mux32_64: the team's 32:1 read multiplexor, W bits wide.
// Ports:
//   din : 32 packed input words, din[k] selected when sel == k
//   sel : 5-bit select
//   dout: selected word
module mux32_64
    import regfile_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [31:0][W-1:0] din,
    input  logic [4:0]         sel,
    output logic [W-1:0]       dout
);

    assign dout = din[sel];

endmodule : mux32_64

// File: rtl/regfile_bypass_reg64_en.sv
// reg64_en: one architectural register with load enable.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset, wins over en
//   en    : load enable (one-hot from the write decoder)
//   d     : value to load
//   q     : stored value
module reg64_en
    import regfile_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : reg64_en

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32 x 64-bit LEGv8 register file, read in ID and written
// from WB, with optional same-cycle write-to-read forwarding. The zero
// register has no storage and always reads 0.
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-low reset; clears all registers and
//                   forces both read ports to 0 while asserted
//   RegWrite      : WB write enable
//   WriteRegister : WB destination index
//   WriteData     : WB value
//   ReadRegister1 : port 1 source index (Rn)
//   ReadRegister2 : port 2 source index (Rm/Rt)
//   ReadData1     : port 1 data, combinational
//   ReadData2     : port 2 data, combinational
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W_P  = DATA_W,
    parameter int NUM_REGS_P = NUM_REGS,
    parameter int ADDR_W_P  = ADDR_W,
    parameter int ZERO_REG  = 31,
    parameter int BYPASS_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic [ADDR_W_P-1:0] WriteRegister,
    input  logic [DATA_W_P-1:0] WriteData,
    input  logic [ADDR_W_P-1:0] ReadRegister1,
    input  logic [ADDR_W_P-1:0] ReadRegister2,
    output logic [DATA_W_P-1:0] ReadData1,
    output logic [DATA_W_P-1:0] ReadData2
);

    localparam logic [ADDR_W_P-1:0] ZERO_IDX = ADDR_W_P'(ZERO_REG);

    logic [NUM_REGS_P-1:0]              we;
    logic [NUM_REGS_P-1:0][DATA_W_P-1:0] stored;
    logic [DATA_W_P-1:0]                rd1_stored;
    logic [DATA_W_P-1:0]                rd2_stored;
    logic                               wr_valid;

    // A write to the zero register is a no-op everywhere, including bypass.
    assign wr_valid = RegWrite && (WriteRegister != ZERO_IDX);

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        we = '0;
        if (wr_valid) begin
            we[WriteRegister] = 1'b1;
        end
    end

    // NOTE: each register clears through its own reset rather than being
    // modelled as a memory array, so reset reaches every entry.
    for (genvar i = 0; i < NUM_REGS_P; i++) begin : g_regs
        if (i == ZERO_REG) begin : g_zero
            assign stored[i] = '0;
        end else begin : g_reg
            reg64_en #(.W(DATA_W_P)) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (we[i]),
                .d     (WriteData),
                .q     (stored[i])
            );
        end
    end

    mux32_64 #(.W(DATA_W_P)) u_rd1_mux (
        .din  (stored),
        .sel  (ReadRegister1),
        .dout (rd1_stored)
    );

    mux32_64 #(.W(DATA_W_P)) u_rd2_mux (
        .din  (stored),
        .sel  (ReadRegister2),
        .dout (rd2_stored)
    );

    // Forwarding: a port reading the register WB is writing this cycle sees
    // the incoming value. During reset both ports read 0, since the stored
    // contents are about to be discarded.
    always_comb begin
        ReadData1 = rd1_stored;
        ReadData2 = rd2_stored;
        if (!reset) begin
            ReadData1 = '0;
            ReadData2 = '0;
        end else if (BYPASS_EN != 0 && wr_valid) begin
            if (WriteRegister == ReadRegister1) ReadData1 = WriteData;
            if (WriteRegister == ReadRegister2) ReadData2 = WriteData;
        end
    end

endmodule : regfile_bypass

// File: tb/tb_regfile_bypass.sv
// Testbench for regfile_bypass: one instance with forwarding, one without,
// sharing the same inputs and checked against an array-based reference.
module tb_regfile_bypass;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

    logic [63:0] mem [32];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_bypass #(.BYPASS_EN(1)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (rd1_b),
        .ReadData2     (rd2_b)
    );

    regfile_bypass #(.BYPASS_EN(0)) dut_n (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (rd1_n),
        .ReadData2     (rd2_n)
    );

    // Reference read: architectural register value seen by a reader,
    // optionally including the write happening this cycle.
    function automatic logic [63:0] exp_read(input logic [4:0] idx, input bit byp);
        if (reset !== 1'b1) return 64'h0;
        if (idx == 5'd31) return 64'h0;
        if (byp && RegWrite && WriteRegister == idx) return WriteData;
        return mem[idx];
    endfunction

    // Advance one clock: update the reference with the pre-edge inputs, then
    // return at the falling edge where the bench drives and samples.
    task automatic cycle();
        @(posedge clk);
        if (reset !== 1'b1) begin
            for (int k = 0; k < 32; k++) mem[k] = 64'h0;
        end else if (RegWrite && WriteRegister != 5'd31) begin
            mem[WriteRegister] = WriteData;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        reset = rst; RegWrite = we; WriteRegister = wr; WriteData = wd;
        ReadRegister1 = r1; ReadRegister2 = r2;
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 5'd5, 64'hDEAD, 5'd5, 5'd5);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (rd1_b !== 64'h0 || rd2_b !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_during_bypass: got %h/%h want 0/0", rd1_b, rd2_b);
            end
            cycle();
        end
        drive(1'b1, 1'b0, 5'd5, 64'h0, 5'd5, 5'd0);
        n_checks++;
        if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_after: got %h %h %h %h want all 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b1, 5'd3, 64'd550, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 1'b1, 5'd20, 64'd0, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 1'b0, 5'd3, 'x, 5'd3, 5'd20);
        n_checks++;
        if (rd1_n !== 64'd550 || rd2_n !== 64'd0) begin
            n_fail++;
            $display("FAIL basic_x3_x20: got %0d/%0d want 550/0", rd1_n, rd2_n);
        end
        cycle();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd4, 5'd3);
        n_checks++;
        if (rd1_b !== 64'd0 || rd2_b !== 64'd550) begin
            n_fail++;
            $display("FAIL basic_x4_hold: got %0d/%0d want 0/550 (X data must not be stored)", rd1_b, rd2_b);
        end
    endtask

    task automatic test_xzr();
        drive(1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        n_checks++;
        if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0) begin
            n_fail++;
            $display("FAIL xzr_during: got %h/%h/%h want 0", rd1_b, rd2_b, rd1_n);
        end
        cycle();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd31, 5'd31);
        n_checks++;
        if (rd1_b !== 64'h0 || rd2_n !== 64'h0) begin
            n_fail++;
            $display("FAIL xzr_after: got %h/%h want 0", rd1_b, rd2_n);
        end
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 1'b0, 5'd0, 64'h0, 5'(k), 5'(31 - k));
            n_checks++;
            if (rd1_n !== exp_read(5'(k), 0) || rd2_n !== exp_read(5'(31 - k), 0)) begin
                n_fail++;
                $display("FAIL xzr_no_side_effect x%0d: got %h want %h", k, rd1_n, exp_read(5'(k), 0));
            end
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd7, 64'h1111, 5'd0, 5'd0);
        cycle();
        drive(1'b1, 1'b1, 5'd7, 64'h2222, 5'd7, 5'd7);
        n_checks++;
        if (rd1_b !== 64'h2222 || rd2_b !== 64'h2222) begin
            n_fail++;
            $display("FAIL bypass_on_pre_edge: got %h/%h want 2222/2222", rd1_b, rd2_b);
        end
        n_checks++;
        if (rd1_n !== 64'h1111 || rd2_n !== 64'h1111) begin
            n_fail++;
            $display("FAIL bypass_off_pre_edge: got %h/%h want 1111/1111", rd1_n, rd2_n);
        end
        cycle();
        drive(1'b1, 1'b0, 5'd7, 64'h0, 5'd7, 5'd7);
        n_checks++;
        if (rd1_b !== 64'h2222 || rd2_b !== 64'h2222 || rd1_n !== 64'h2222 || rd2_n !== 64'h2222) begin
            n_fail++;
            $display("FAIL bypass_post_edge: got %h %h %h %h want 2222", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 31; k++) begin
            drive(1'b1, 1'b1, 5'(k), 64'(k) * 64'h0101_0101_0101_0101, 5'd0, 5'd0);
            cycle();
        end
        for (int k = 0; k < 32; k++) begin
            logic [63:0] want;
            want = (k == 31) ? 64'h0 : 64'(k) * 64'h0101_0101_0101_0101;
            drive(1'b1, 1'b0, 5'd0, 64'h0, 5'(k), 5'(k));
            n_checks++;
            if (rd1_b !== want || rd2_b !== want || rd1_n !== want || rd2_n !== want) begin
                n_fail++;
                $display("FAIL sweep x%0d: got %h %h %h %h want %h", k, rd1_b, rd2_b, rd1_n, rd2_n, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 5'd10, 64'hABCD, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b1, 5'd11, 64'h5, 5'd10, 5'd11);
        cycle();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 5'd10, 5'd11);
        n_checks++;
        if (rd1_b !== 64'h0 || rd2_b !== 64'h0 || rd1_n !== 64'h0 || rd2_n !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h %h %h %h want all 0", rd1_b, rd2_b, rd1_n, rd2_n);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] wr;
            logic [4:0] r1;
            logic [4:0] r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), wr,
                  {$urandom, $urandom}, r1, r2);
            n_checks++;
            if (rd1_b !== exp_read(r1, 1) || rd2_b !== exp_read(r2, 1) ||
                rd1_n !== exp_read(r1, 0) || rd2_n !== exp_read(r2, 0)) begin
                n_fail++;
                $display("FAIL random cyc%0d r%0d/r%0d: got %h %h %h %h want %h %h %h %h", c, r1, r2,
                         rd1_b, rd2_b, rd1_n, rd2_n,
                         exp_read(r1, 1), exp_read(r2, 1), exp_read(r1, 0), exp_read(r2, 0));
            end
            cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 64'h0;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        cycle();
        test_basic();
        test_xzr();
        test_bypass();
        test_sweep();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_bypass
